// File: rtl/rbi_mem_l2_ring_sched.sv
// L2 ring-stop scheduler: DC responses bypass the slow chain through a FIFO that fills empty
// ring output slots, and DRAM-window requests recirculate into empty DC input slots.

module rbi_mem_l2_ring_sched_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PW:0]   count_q, count_d;

   // Power-of-two depth lets the pointers wrap naturally; the counter resolves full vs empty.
   always_comb begin
      wp_d    = push ? wp_q + 1'b1 : wp_q;
      rp_d    = pop ? rp_q + 1'b1 : rp_q;
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wp_q] <= wdata;
      end
   end

   assign rdata = mem_q[rp_q];
   assign count = count_q;
endmodule

module rbi_mem_l2_ring_sched #(
   parameter int         TILE_W    = 128,
   parameter int         RSP_DEPTH = 4,
   parameter int         REC_DEPTH = 2,
   parameter int         STALL_LIM = 64,
   parameter logic [7:0] OPM_LDX   = 8'h20,
   parameter logic [7:0] OPM_STX   = 8'h21
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [15:0]                memSeqIn,
   input  logic [15:0]                memOpmIn,
   input  logic [47:0]                memAddrIn,
   input  logic [TILE_W-1:0]          memDataIn,
   output logic [15:0]                memSeqOut,
   output logic [15:0]                memOpmOut,
   output logic [47:0]                memAddrOut,
   output logic [TILE_W-1:0]          memDataOut,
   output logic [15:0]                l2mSeqIn,
   output logic [15:0]                l2mOpmIn,
   output logic [47:0]                l2mAddrIn,
   output logic [TILE_W-1:0]          l2mDataIn,
   input  logic [15:0]                l2mSeqOut,
   input  logic [15:0]                l2mOpmOut,
   input  logic [47:0]                l2mAddrOut,
   input  logic [TILE_W-1:0]          l2mDataOut,
   output logic [15:0]                l2bSeqIn,
   output logic [15:0]                l2bOpmIn,
   output logic [47:0]                l2bAddrIn,
   output logic [TILE_W-1:0]          l2bDataIn,
   input  logic [15:0]                l2bSeqOut,
   input  logic [15:0]                l2bOpmOut,
   input  logic [47:0]                l2bAddrOut,
   input  logic [TILE_W-1:0]          l2bDataOut,
   output logic [$clog2(RSP_DEPTH):0] rspCount,
   output logic [$clog2(REC_DEPTH):0] recCount,
   output logic                       deadlockStrobe
);
   localparam int MSG_W   = 80 + TILE_W;
   localparam int RSP_CW  = $clog2(RSP_DEPTH) + 1;
   localparam int REC_CW  = $clog2(REC_DEPTH) + 1;
   localparam int STALL_W = $clog2(STALL_LIM + 1);
   localparam logic [RSP_CW-1:0]  RSP_FULL  = RSP_CW'(RSP_DEPTH);
   localparam logic [REC_CW-1:0]  REC_FULL  = REC_CW'(REC_DEPTH);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIM);

   logic [MSG_W-1:0]   mem_in_msg, dc_in_msg, dc_out_msg, sc_out_msg;
   logic [MSG_W-1:0]   rsp_rdata, rec_rdata;
   logic [MSG_W-1:0]   l2b_in_q, l2b_in_d, mem_out_q, mem_out_d;
   logic [RSP_CW-1:0]  rsp_count;
   logic [REC_CW-1:0]  rec_count;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               strobe_q, strobe_d;
   logic               rsp_push, rsp_pop, rec_push, rec_pop;
   logic               dc_is_rsp, dc_is_drq, dc_empty, sc_empty, rec_full;

   // Slot routing: whatever the FIFOs absorb leaves an EMPTY slot on the slow chain.
   always_comb begin
      mem_in_msg = {memSeqIn, memOpmIn, memAddrIn, memDataIn};
      dc_out_msg = {l2mSeqOut, l2mOpmOut, l2mAddrOut, l2mDataOut};
      sc_out_msg = {l2bSeqOut, l2bOpmOut, l2bAddrOut, l2bDataOut};

      rec_pop   = (memOpmIn[7:0] == 8'h00) && (rec_count != '0);
      dc_in_msg = rec_pop ? rec_rdata : mem_in_msg;

      dc_empty  = (l2mOpmOut[7:0] == 8'h00);
      dc_is_rsp = (l2mOpmOut[7:6] == 2'b01);
      dc_is_drq = ((l2mOpmOut[7:0] == OPM_LDX) || (l2mOpmOut[7:0] == OPM_STX)) &&
                  (l2mAddrOut[29:24] != 6'd0) && (l2mAddrOut[31:30] == 2'b00);
      rsp_push  = dc_is_rsp && (rsp_count != RSP_FULL);
      rec_push  = dc_is_drq && (rec_count != REC_FULL);
      l2b_in_d  = (rsp_push || rec_push || dc_empty) ? '0 : dc_out_msg;

      sc_empty = (l2bOpmOut[7:0] == 8'h00);
      rsp_pop  = sc_empty && (rsp_count != '0);
      if (rsp_pop) begin
         mem_out_d = rsp_rdata;
      end else if (sc_empty) begin
         mem_out_d = '0;
      end else begin
         mem_out_d = sc_out_msg;
      end
   end

   // The strobe fires on the single edge where the stall counter first reaches the limit.
   always_comb begin
      rec_full = (rec_count == REC_FULL);
      stall_d  = '0;
      strobe_d = 1'b0;
      if (rec_full) begin
         stall_d  = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
         strobe_d = (stall_q == STALL_MAX - 1'b1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         l2b_in_q  <= '0;
         mem_out_q <= '0;
         stall_q   <= '0;
         strobe_q  <= 1'b0;
      end else begin
         l2b_in_q  <= l2b_in_d;
         mem_out_q <= mem_out_d;
         stall_q   <= stall_d;
         strobe_q  <= strobe_d;
      end
   end

   rbi_mem_l2_ring_sched_fifo #(.W(MSG_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rsp_push),
      .pop   (rsp_pop),
      .wdata (dc_out_msg),
      .rdata (rsp_rdata),
      .count (rsp_count)
   );

   rbi_mem_l2_ring_sched_fifo #(.W(MSG_W), .DEPTH(REC_DEPTH)) u_rec_fifo (
      .clock (clock),
      .reset (reset),
      .push  (rec_push),
      .pop   (rec_pop),
      .wdata (dc_out_msg),
      .rdata (rec_rdata),
      .count (rec_count)
   );

   assign {l2mSeqIn, l2mOpmIn, l2mAddrIn, l2mDataIn}     = dc_in_msg;
   assign {l2bSeqIn, l2bOpmIn, l2bAddrIn, l2bDataIn}     = l2b_in_q;
   assign {memSeqOut, memOpmOut, memAddrOut, memDataOut} = mem_out_q;
   assign rspCount       = rsp_count;
   assign recCount       = rec_count;
   assign deadlockStrobe = strobe_q;
endmodule

// File: tb/tb_rbi_mem_l2_ring_sched.sv
// Directed bench for the L2 ring-stop scheduler, plus a random conservation run that uses
// small behavioural models of the DRAM cache and the slow chain.

module tb_rbi_mem_l2_ring_sched;
   localparam int TILE_W = 128;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [15:0]       mem_seq_in, mem_opm_in, mem_seq_out, mem_opm_out;
   logic [47:0]       mem_addr_in, mem_addr_out;
   logic [TILE_W-1:0] mem_data_in, mem_data_out;
   logic [15:0]       l2m_seq_in, l2m_opm_in, l2m_seq_out, l2m_opm_out;
   logic [47:0]       l2m_addr_in, l2m_addr_out;
   logic [TILE_W-1:0] l2m_data_in, l2m_data_out;
   logic [15:0]       l2b_seq_in, l2b_opm_in, l2b_seq_out, l2b_opm_out;
   logic [47:0]       l2b_addr_in, l2b_addr_out;
   logic [TILE_W-1:0] l2b_data_in, l2b_data_out;
   logic [2:0]        rsp_count;
   logic [1:0]        rec_count;
   logic              deadlock_strobe;

   logic              rand_mode;
   logic [15:0]       dir_dc_seq, dir_dc_opm, dir_sc_seq, dir_sc_opm;
   logic [47:0]       dir_dc_addr;
   logic [TILE_W-1:0] dir_dc_data, dir_sc_data;
   logic [15:0]       dc_seq_q, dc_opm_q, sc_seq_q, sc_opm_q;
   logic [47:0]       dc_addr_q, sc_addr_q;
   logic [TILE_W-1:0] dc_data_q, sc_data_q;

   int checks = 0;
   int errors = 0;

   rbi_mem_l2_ring_sched dut (
      .clock          (clock),
      .reset          (reset),
      .memSeqIn       (mem_seq_in),
      .memOpmIn       (mem_opm_in),
      .memAddrIn      (mem_addr_in),
      .memDataIn      (mem_data_in),
      .memSeqOut      (mem_seq_out),
      .memOpmOut      (mem_opm_out),
      .memAddrOut     (mem_addr_out),
      .memDataOut     (mem_data_out),
      .l2mSeqIn       (l2m_seq_in),
      .l2mOpmIn       (l2m_opm_in),
      .l2mAddrIn      (l2m_addr_in),
      .l2mDataIn      (l2m_data_in),
      .l2mSeqOut      (l2m_seq_out),
      .l2mOpmOut      (l2m_opm_out),
      .l2mAddrOut     (l2m_addr_out),
      .l2mDataOut     (l2m_data_out),
      .l2bSeqIn       (l2b_seq_in),
      .l2bOpmIn       (l2b_opm_in),
      .l2bAddrIn      (l2b_addr_in),
      .l2bDataIn      (l2b_data_in),
      .l2bSeqOut      (l2b_seq_out),
      .l2bOpmOut      (l2b_opm_out),
      .l2bAddrOut     (l2b_addr_out),
      .l2bDataOut     (l2b_data_out),
      .rspCount       (rsp_count),
      .recCount       (rec_count),
      .deadlockStrobe (deadlock_strobe)
   );

   // DC model: LDX comes back as STX, STX comes back as a response, everything else echoes.
   always_ff @(posedge clock) begin
      dc_seq_q  <= l2m_seq_in;
      dc_addr_q <= l2m_addr_in;
      dc_data_q <= l2m_data_in;
      if (l2m_opm_in[7:0] == 8'h20) dc_opm_q <= 16'h0021;
      else if (l2m_opm_in[7:0] == 8'h21) dc_opm_q <= 16'h0040;
      else dc_opm_q <= l2m_opm_in;
      sc_seq_q  <= l2b_seq_in;
      sc_opm_q  <= l2b_opm_in;
      sc_addr_q <= l2b_addr_in;
      sc_data_q <= l2b_data_in;
   end

   assign l2m_seq_out  = rand_mode ? dc_seq_q  : dir_dc_seq;
   assign l2m_opm_out  = rand_mode ? dc_opm_q  : dir_dc_opm;
   assign l2m_addr_out = rand_mode ? dc_addr_q : dir_dc_addr;
   assign l2m_data_out = rand_mode ? dc_data_q : dir_dc_data;
   assign l2b_seq_out  = rand_mode ? sc_seq_q  : dir_sc_seq;
   assign l2b_opm_out  = rand_mode ? sc_opm_q  : dir_sc_opm;
   assign l2b_addr_out = rand_mode ? sc_addr_q : 48'h0;
   assign l2b_data_out = rand_mode ? sc_data_q : dir_sc_data;

   function automatic logic [TILE_W-1:0] tile(input logic [15:0] seq, input logic [15:0] opm);
      return (opm[7:0] != 8'h00) ? {8{seq}} : '0;
   endfunction

   task automatic applyStimulus(input logic [15:0] m_seq, input logic [15:0] m_opm,
                                input logic [47:0] m_addr, input logic [15:0] d_seq,
                                input logic [15:0] d_opm, input logic [47:0] d_addr,
                                input logic [15:0] s_seq, input logic [15:0] s_opm);
      mem_seq_in  = m_seq;
      mem_opm_in  = m_opm;
      mem_addr_in = m_addr;
      mem_data_in = tile(m_seq, m_opm);
      dir_dc_seq  = d_seq;
      dir_dc_opm  = d_opm;
      dir_dc_addr = d_addr;
      dir_dc_data = tile(d_seq, d_opm);
      dir_sc_seq  = s_seq;
      dir_sc_opm  = s_opm;
      dir_sc_data = tile(s_seq, s_opm);
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fillAndHold(input string tag);
      int strobe_cnt;
      int strobe_at;
      strobe_cnt = 0;
      strobe_at  = 0;
      applyStimulus(16'h0D02, 16'h0090, 48'h0, 16'h0E01, 16'h0021, 48'h0000_0200_0000, 16'h0, 16'h0);
      tick();
      applyStimulus(16'h0D03, 16'h0090, 48'h0, 16'h0E02, 16'h0020, 48'h0000_0200_0000, 16'h0, 16'h0);
      tick();
      checkOutput({tag, "_rec_full"}, 128'(rec_count), 128'd2);
      applyStimulus(16'h0D04, 16'h0090, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (deadlock_strobe) begin
            strobe_cnt++;
            strobe_at = i;
         end
      end
      checkOutput({tag, "_strobe_count"}, 128'(strobe_cnt), 128'd1);
      checkOutput({tag, "_strobe_cycle"}, 128'(strobe_at), 128'd64);
   endtask

   byte unsigned seen_cnt [65536];
   bit           issued   [65536];

   initial begin
      int          ghosts;
      int          bad;
      int          n_issued;
      int          n_seen;
      logic [15:0] next_seq;
      logic [15:0] r_opm;
      logic [47:0] r_addr;

      rand_mode = 1'b0;
      reset     = 1'b1;
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
      #12;
      checkOutput("reset_mem_opm", 128'(mem_opm_out), 128'h0);
      checkOutput("reset_l2b_opm", 128'(l2b_opm_in), 128'h0);
      checkOutput("reset_rsp_count", 128'(rsp_count), 128'h0);
      checkOutput("reset_rec_count", 128'(rec_count), 128'h0);
      checkOutput("reset_strobe", 128'(deadlock_strobe), 128'h0);
      tick();
      reset = 1'b0;

      // Single response into an idle ring output.
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h1234, 16'h0040, 48'h0, 16'h0, 16'h0);
      tick();
      checkOutput("rsp1_count_after_push", 128'(rsp_count), 128'd1);
      checkOutput("rsp1_l2b_emptied", 128'(l2b_opm_in), 128'h0);
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
      tick();
      checkOutput("rsp1_mem_seq", 128'(mem_seq_out), 128'h1234);
      checkOutput("rsp1_mem_opm", 128'(mem_opm_out), 128'h0040);
      checkOutput("rsp1_mem_data", 128'(mem_data_out), {8{16'h1234}});
      checkOutput("rsp1_count_drained", 128'(rsp_count), 128'd0);

      // Five responses while the slow chain keeps the ring output busy.
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(16'h0, 16'h0, 48'h0, 16'h0A00 + 16'(k), 16'h0040, 48'h0,
                       16'hB000 + 16'(k), 16'h0090);
         tick();
         checkOutput("busy_mem_seq", 128'(mem_seq_out), 128'(16'hB000 + 16'(k)));
      end
      checkOutput("rsp5_count_full", 128'(rsp_count), 128'd4);
      checkOutput("rsp5_fallback_seq", 128'(l2b_seq_in), 128'h0A05);
      checkOutput("rsp5_fallback_opm", 128'(l2b_opm_in), 128'h0040);
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0A05, 16'h0040);
      tick();
      checkOutput("rsp5_slow_seq", 128'(mem_seq_out), 128'h0A05);
      checkOutput("rsp5_count_held", 128'(rsp_count), 128'd4);
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checkOutput("rsp5_fifo_order", 128'(mem_seq_out), 128'(16'h0A00 + 16'(k)));
      end
      checkOutput("rsp5_count_drained", 128'(rsp_count), 128'd0);

      // Recirculation of a DRAM-window request into the next empty input slot.
      applyStimulus(16'h0D01, 16'h0090, 48'h0, 16'h0C01, 16'h0020, 48'h0000_0100_0000,
                    16'h0, 16'h0);
      #1;
      checkOutput("rec_forward_busy_in", 128'(l2m_seq_in), 128'h0D01);
      tick();
      checkOutput("rec_count_push", 128'(rec_count), 128'd1);
      checkOutput("rec_l2b_emptied", 128'(l2b_opm_in), 128'h0);
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0C02, 16'h0020, 48'h0000_4000_0000,
                    16'h0, 16'h0);
      #1;
      checkOutput("rec_reenter_seq", 128'(l2m_seq_in), 128'h0C01);
      checkOutput("rec_reenter_opm", 128'(l2m_opm_in), 128'h0020);
      checkOutput("rec_reenter_addr", 128'(l2m_addr_in), 128'h0000_0100_0000);
      tick();
      checkOutput("rec_count_pop", 128'(rec_count), 128'd0);
      checkOutput("nonwindow_to_slow_seq", 128'(l2b_seq_in), 128'h0C02);
      checkOutput("nonwindow_to_slow_addr", 128'(l2b_addr_in), 128'h0000_4000_0000);
      checkOutput("empty_in_no_rec", 128'(l2m_opm_in), 128'h0);

      // Deadlock strobe, then drain and re-arm.
      fillAndHold("stall1");
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
      tick();
      tick();
      checkOutput("stall_drain_count", 128'(rec_count), 128'd0);
      fillAndHold("stall2");

      // Reset in the middle of traffic discards queued responses.
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
      tick();
      tick();
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(16'h0, 16'h0, 48'h0, 16'h0F00 + 16'(k), 16'h0040, 48'h0,
                       16'h0B10, 16'h0090);
         tick();
      end
      checkOutput("midreset_rsp_queued", 128'(rsp_count), 128'd3);
      reset = 1'b1;
      #2;
      checkOutput("midreset_mem_opm", 128'(mem_opm_out), 128'h0);
      checkOutput("midreset_rsp_count", 128'(rsp_count), 128'd0);
      applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
      tick();
      reset  = 1'b0;
      ghosts = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (mem_opm_out != 16'h0) ghosts++;
      end
      checkOutput("midreset_no_ghosts", 128'(ghosts), 128'd0);

      // Random traffic through the DC and slow-chain models; every Seq must exit exactly once.
      rand_mode = 1'b1;
      next_seq  = 16'h1000;
      n_issued  = 0;
      n_seen    = 0;
      for (int cyc = 0; cyc < 3200; cyc++) begin
         if (cyc < 3000 && $urandom_range(0, 9) >= 4) begin
            case ($urandom_range(0, 3))
               0: begin r_opm = 16'h0040; r_addr = 48'h0; end
               1: begin r_opm = 16'h0020; r_addr = 48'h0000_0100_0000; end
               2: begin r_opm = 16'h0021; r_addr = 48'h0000_4000_0000; end
               default: begin r_opm = 16'h0090; r_addr = 48'h0000_0000_1000; end
            endcase
            issued[next_seq] = 1'b1;
            n_issued++;
            applyStimulus(next_seq, r_opm, r_addr, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
            next_seq = next_seq + 16'd1;
         end else begin
            applyStimulus(16'h0, 16'h0, 48'h0, 16'h0, 16'h0, 48'h0, 16'h0, 16'h0);
         end
         tick();
         if (mem_opm_out[7:0] != 8'h00) begin
            seen_cnt[mem_seq_out] = seen_cnt[mem_seq_out] + 8'd1;
            n_seen++;
         end
      end
      bad = 0;
      for (int s = 0; s < 65536; s++) begin
         if (issued[s] ? (seen_cnt[s] != 8'd1) : (seen_cnt[s] != 8'd0)) bad++;
      end
      checkOutput("random_bad_seqs", 128'(bad), 128'd0);
      checkOutput("random_out_total", 128'(n_seen), 128'(n_issued));
      checkOutput("random_rsp_drained", 128'(rsp_count), 128'd0);
      checkOutput("random_rec_drained", 128'(rec_count), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
